// File: rtl/cdb_pkg.sv
// cdb_pkg: shared CDB sizes, functional-unit indices and reservation-station selector encoding
package cdb_pkg;
  localparam int N_REQ = 4;
  localparam int DATA_W = 32;
  localparam int LABEL_W = 4;
  localparam int FU_ALU = 0;
  localparam int FU_MUL = 1;
  localparam int FU_DIV = 2;
  localparam int FU_LS = 3;
  localparam int NO_LABEL = 0;
  typedef enum logic [1:0] {RS_ALU, RS_MUL, RS_DIV, RS_LS} rs_sel_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first valid index scanning from ptr upward with wrap
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] g,
  output logic         any_grant
);
  always_comb begin
    grant = '0;
    g = '0;
    any_grant = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid[(int'(ptr) + k) % N]) begin
        grant = '0;
        grant[(int'(ptr) + k) % N] = 1'b1;
        g = W'((int'(ptr) + k) % N);
        any_grant = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdb_scheduler.sv
// cdb_scheduler: registered round-robin arbiter driving the common data bus broadcast
module cdb_scheduler import cdb_pkg::*; #(
  parameter int N_REQ = cdb_pkg::N_REQ,
  parameter int DATA_W = cdb_pkg::DATA_W,
  parameter int LABEL_W = cdb_pkg::LABEL_W
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic [N_REQ-1:0]           require,
  input  logic [N_REQ*DATA_W-1:0]    reqData,
  input  logic [N_REQ*LABEL_W-1:0]   reqLabel,
  output logic [N_REQ-1:0]           requireAC,
  output logic                       BCEN,
  output logic [LABEL_W-1:0]         BClabel,
  output logic [DATA_W-1:0]          BCdata,
  output logic                       tagErr,
  output logic [15:0]                grantCnt
);
  localparam int PW = $clog2(N_REQ);
  logic [LABEL_W-1:0] labels [N_REQ];
  logic [DATA_W-1:0] datas [N_REQ];
  logic [N_REQ-1:0] valid;
  logic [PW-1:0] ptr, g;
  logic any_grant;
  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign labels[i] = reqLabel[i*LABEL_W +: LABEL_W];
    assign datas[i] = reqData[i*DATA_W +: DATA_W];
    assign valid[i] = require[i] && labels[i] != LABEL_W'(NO_LABEL);
  end
  rr_pick #(.N(N_REQ)) u_pick (
    .valid(valid),
    .ptr(ptr),
    .grant(requireAC),
    .g(g),
    .any_grant(any_grant)
  );
  always_ff @(posedge clk) begin
    if (!nRST) begin
      BCEN <= 1'b0;
      BClabel <= '0;
      BCdata <= '0;
      ptr <= '0;
      tagErr <= 1'b0;
      grantCnt <= '0;
    end else begin
      BCEN <= any_grant;
      BClabel <= any_grant ? labels[g] : '0;
      BCdata <= any_grant ? datas[g] : '0;
      ptr <= any_grant ? ((int'(g) == N_REQ - 1) ? '0 : g + 1'b1) : ptr;
      grantCnt <= grantCnt + 16'(any_grant);
      tagErr <= tagErr | (|(require & ~valid));
    end
  end
endmodule

// File: tb/tb_cdb_scheduler.sv
// tb_cdb_scheduler: table-driven scoreboard bench for the CDB round-robin scheduler
module tb_cdb_scheduler;
  logic clk = 1'b0;
  logic nRST = 1'b0;
  logic [3:0] require = '0;
  logic [127:0] reqData = '0;
  logic [15:0] reqLabel = '0;
  logic [3:0] requireAC;
  logic BCEN;
  logic [3:0] BClabel;
  logic [31:0] BCdata;
  logic tagErr;
  logic [15:0] grantCnt;
  typedef struct {
    logic nrst;
    logic [3:0] req;
    logic [15:0] lab;
    logic [3:0] ac;
    logic tag;
  } vec_t;
  typedef struct {
    logic en;
    logic [3:0] label;
    logic [31:0] data;
    logic [15:0] cnt;
    logic tag;
  } exp_t;
  vec_t vecs[$];
  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  logic [15:0] cnt_m = '0;
  cdb_scheduler dut (
    .clk(clk),
    .nRST(nRST),
    .require(require),
    .reqData(reqData),
    .reqLabel(reqLabel),
    .requireAC(requireAC),
    .BCEN(BCEN),
    .BClabel(BClabel),
    .BCdata(BCdata),
    .tagErr(tagErr),
    .grantCnt(grantCnt)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] dat(int i, logic [3:0] l);
    return 32'(i) * 32'h1000_0000 + 32'(l) * 32'd4 + 32'd1;
  endfunction
  function automatic vec_t mk(logic n, logic [3:0] r, logic [15:0] l, logic [3:0] a, logic t);
    vec_t v;
    v.nrst = n;
    v.req = r;
    v.lab = l;
    v.ac = a;
    v.tag = t;
    return v;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask
  task automatic apply(vec_t v, int n);
    exp_t e;
    exp_t o;
    int gi;
    @(negedge clk);
    nRST = v.nrst;
    require = v.req;
    reqLabel = v.lab;
    for (int i = 0; i < 4; i++) reqData[i*32 +: 32] = dat(i, v.lab[i*4 +: 4]);
    #1 chk($sformatf("requireAC[v%0d]", n), 32'(requireAC), 32'(v.ac));
    gi = 0;
    for (int i = 0; i < 4; i++) if (v.ac[i]) gi = i;
    e.en = v.nrst && (v.ac != 0);
    e.label = e.en ? v.lab[gi*4 +: 4] : 4'd0;
    e.data = e.en ? dat(gi, v.lab[gi*4 +: 4]) : 32'd0;
    cnt_m = !v.nrst ? 16'd0 : cnt_m + 16'(e.en);
    e.cnt = cnt_m;
    e.tag = v.tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    chk($sformatf("BCEN[v%0d]", n), 32'(BCEN), 32'(o.en));
    chk($sformatf("BClabel[v%0d]", n), 32'(BClabel), 32'(o.label));
    chk($sformatf("BCdata[v%0d]", n), BCdata, o.data);
    chk($sformatf("grantCnt[v%0d]", n), 32'(grantCnt), 32'(o.cnt));
    chk($sformatf("tagErr[v%0d]", n), 32'(tagErr), 32'(o.tag));
  endtask
  initial begin
    vecs.push_back(mk(0, 4'b0000, 16'h0000, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 16'h0000, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b0000, 16'h0000, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b0001, 16'h0001, 4'b0001, 0));
    vecs.push_back(mk(1, 4'b0000, 16'h0000, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b1000, 16'h4000, 4'b1000, 0));
    vecs.push_back(mk(1, 4'b1111, 16'h4321, 4'b0001, 0));
    vecs.push_back(mk(1, 4'b1111, 16'h4321, 4'b0010, 0));
    vecs.push_back(mk(1, 4'b1111, 16'h4321, 4'b0100, 0));
    vecs.push_back(mk(1, 4'b1111, 16'h4321, 4'b1000, 0));
    vecs.push_back(mk(1, 4'b1111, 16'h4321, 4'b0001, 0));
    vecs.push_back(mk(1, 4'b1111, 16'h4321, 4'b0010, 0));
    vecs.push_back(mk(1, 4'b1010, 16'h9050, 4'b1000, 0));
    vecs.push_back(mk(1, 4'b0010, 16'h0050, 4'b0010, 0));
    vecs.push_back(mk(1, 4'b0101, 16'h0003, 4'b0001, 1));
    vecs.push_back(mk(1, 4'b0100, 16'h0000, 4'b0000, 1));
    vecs.push_back(mk(1, 4'b0100, 16'h0700, 4'b0100, 1));
    vecs.push_back(mk(1, 4'b0000, 16'h0000, 4'b0000, 1));
    vecs.push_back(mk(0, 4'b1111, 16'h4321, 4'b1000, 0));
    vecs.push_back(mk(1, 4'b1111, 16'h4321, 4'b0001, 0));
    vecs.push_back(mk(1, 4'b0000, 16'h0000, 4'b0000, 0));
    for (int n = 0; n < vecs.size(); n++) apply(vecs[n], n);
    apply(mk(0, 4'b0000, 16'h0000, 4'b0000, 0), 99);
    @(negedge clk);
    nRST = 1'b1;
    require = 4'b0001;
    reqLabel = 16'h0001;
    reqData = '0;
    reqData[31:0] = dat(0, 4'd1);
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap_pre_cnt", 32'(grantCnt), 32'h0000_FFFF);
    chk("wrap_pre_en", 32'(BCEN), 32'd1);
    chk("wrap_pre_data", BCdata, 32'd5);
    @(posedge clk);
    #1;
    chk("wrap_cnt", 32'(grantCnt), 32'd0);
    chk("wrap_en", 32'(BCEN), 32'd1);
    @(negedge clk);
    require = 4'b0000;
    @(posedge clk);
    #1;
    chk("wrap_idle_en", 32'(BCEN), 32'd0);
    chk("wrap_idle_cnt", 32'(grantCnt), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
